// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD, payload, optional zero pad, CRC-32 FCS, inter-frame gap.
// Define GMII_TX_PAD_EN to pad short frames to MIN_FRAME bytes before the FCS.
module gmii_tx_framer #(
    parameter int PREAMBLE_LEN = 7,
    parameter int IFG_BYTES    = 12,
`ifdef GMII_TX_PAD_EN
    parameter int MIN_FRAME    = 60,
`endif
    parameter int MAX_FRAME    = 1514
) (
    input  logic       gmii_tx_clk,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic       gmii_tx_en,
    output logic [7:0] gmii_tx_data,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       err_underrun,
    output logic       err_oversize
);

    typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, DISCARD, IFG} state_t;

    state_t      state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic [15:0] count_q, count_d;
    logic [15:0] timer_q, timer_d;
    logic        err_q, err_d;
    logic        last_q, last_d;
    logic        tx_en_q, tx_en_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        done_q, done_d;
    logic        underrun_q, underrun_d;
    logic        oversize_q, oversize_d;

    logic        accept;
    logic        in_data;
    logic        at_max;
    logic        pad_needed;
    logic [15:0] count_inc;
    logic [31:0] fcs_word;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    assign in_data   = (state_q == SFD) || (state_q == DATA);
    assign accept    = s_valid && s_ready;
    assign count_inc = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
    assign at_max    = (count_q == 16'(MAX_FRAME - 1));
    // An errored frame carries the raw register, i.e. the complement of the good FCS.
    assign fcs_word  = err_q ? crc_q : ~crc_q;
`ifdef GMII_TX_PAD_EN
    assign pad_needed = (count_inc < 16'(MIN_FRAME));
`else
    assign pad_needed = 1'b0;
`endif

    always_comb begin
        unique case (state_q)
            SFD, DATA, DISCARD: s_ready = 1'b1;
            FCS:                s_ready = err_q && !last_q;
            default:            s_ready = 1'b0;
        endcase
    end

    always_ff @(posedge gmii_tx_clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            crc_q      <= 32'hFFFFFFFF;
            count_q    <= '0;
            timer_q    <= '0;
            err_q      <= 1'b0;
            last_q     <= 1'b0;
            tx_en_q    <= 1'b0;
            tx_data_q  <= '0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
            oversize_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            crc_q      <= crc_d;
            count_q    <= count_d;
            timer_q    <= timer_d;
            err_q      <= err_d;
            last_q     <= last_d;
            tx_en_q    <= tx_en_d;
            tx_data_q  <= tx_data_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
            oversize_q <= oversize_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (s_valid) state_d = PRE;
            PRE:     if (timer_q == 16'(PREAMBLE_LEN - 1)) state_d = SFD;
            SFD, DATA: begin
                if (!s_valid)    state_d = FCS;
                else if (s_last) state_d = pad_needed ? PAD : FCS;
                else if (at_max) state_d = FCS;
                else             state_d = DATA;
            end
`ifdef GMII_TX_PAD_EN
            PAD:     if (count_q == 16'(MIN_FRAME - 1)) state_d = FCS;
`endif
            FCS: begin
                if (timer_q == 16'd3)
                    state_d = (err_q && !last_q && !(accept && s_last)) ? DISCARD : IFG;
            end
            DISCARD: if (accept && s_last) state_d = IFG;
            IFG:     if (timer_q == 16'(IFG_BYTES - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Frame datapath: CRC, byte count, error flags and the shared per-state timer.
    always_comb begin
        crc_d   = crc_q;
        count_d = count_q;
        err_d   = err_q;
        last_d  = last_q;
        timer_d = (state_d != state_q) ? 16'd0 : timer_q + 16'd1;
        unique case (state_q)
            IDLE: begin
                crc_d   = 32'hFFFFFFFF;
                count_d = '0;
                err_d   = 1'b0;
                last_d  = 1'b0;
            end
            SFD, DATA: begin
                if (s_valid) begin
                    crc_d   = crc_byte(crc_q, s_data);
                    count_d = count_inc;
                    if (!s_last && at_max) err_d = 1'b1;
                end else begin
                    err_d   = 1'b1;
                    timer_d = 16'd1;
                end
            end
            PAD: begin
                crc_d   = crc_byte(crc_q, 8'h00);
                count_d = count_inc;
            end
            FCS:     if (accept && s_last) last_d = 1'b1;
            default: ;
        endcase
    end

    // Registered GMII outputs are computed one cycle ahead of when they appear.
    always_comb begin
        tx_en_d    = 1'b0;
        tx_data_d  = 8'h00;
        done_d     = 1'b0;
        underrun_d = 1'b0;
        oversize_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_en_d   = s_valid;
                tx_data_d = s_valid ? 8'h55 : 8'h00;
            end
            PRE: begin
                tx_en_d   = 1'b1;
                tx_data_d = (timer_q == 16'(PREAMBLE_LEN - 1)) ? 8'hD5 : 8'h55;
            end
            SFD, DATA: begin
                tx_en_d = 1'b1;
                if (s_valid) begin
                    tx_data_d  = s_data;
                    oversize_d = !s_last && at_max;
                end else begin
                    tx_data_d  = crc_q[7:0];
                    underrun_d = 1'b1;
                end
            end
            PAD:     tx_en_d = 1'b1;
            FCS: begin
                tx_en_d   = 1'b1;
                tx_data_d = fcs_word[8*timer_q[1:0] +: 8];
            end
            IFG:     done_d = (timer_q == 16'd0);
            default: ;
        endcase
    end

    assign gmii_tx_en   = tx_en_q;
    assign gmii_tx_data = tx_data_q;
    assign tx_busy      = (state_q != IDLE);
    assign tx_done      = done_q;
    assign err_underrun = underrun_q;
    assign err_oversize = oversize_q;

endmodule
